// File: rtl/vga_timing_gen_pkg.sv
// Default 640x480@60 raster timing and small helpers shared by the timing generator.
package vga_timing_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int CW_DEF       = 10;
    localparam int FCW_DEF      = 8;

    localparam bit SYNC_ACTIVE_LOW = 1'b0;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle driven by the generator (master) towards display/renderer logic (slave).
interface vga_timing_gen_if
    import vga_timing_pkg::*;
#(
    parameter int CW  = CW_DEF,
    parameter int FCW = FCW_DEF
);
    logic           hsync;
    logic           vsync;
    logic           blank;
    logic           de;
    logic [CW-1:0]  x;
    logic [CW-1:0]  y;
    logic [CW-1:0]  fetch_x;
    logic [CW-1:0]  fetch_y;
    logic           fetch_de;
    logic           line_start;
    logic           frame_start;
    logic           vblank_start;
    logic [FCW-1:0] frame_count;

    modport master (
        output hsync, vsync, blank, de, x, y, fetch_x, fetch_y, fetch_de,
               line_start, frame_start, vblank_start, frame_count
    );

    modport slave (
        input  hsync, vsync, blank, de, x, y, fetch_x, fetch_y, fetch_de,
               line_start, frame_start, vblank_start, frame_count
    );
endinterface

// File: rtl/vga_timing_gen_axis_counter.sv
// Modulo-TOTAL position counter; wrap flags the enabled step that returns the count to 0.
module vga_axis_counter #(
    parameter int TOTAL     = 800,
    parameter int RESET_VAL = 0,
    parameter int CW        = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          wrap
);
    localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);
    localparam logic [CW-1:0] RST  = CW'(RESET_VAL);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        wrap    = en && (count_q == LAST);
        count_d = count_q;
        if (en) count_d = wrap ? '0 : count_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= RST;
        else       count_q <= count_d;
    end

    assign count = count_q;
endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: registered sync/blank/position, lookahead fetch
// coordinate, line/frame/vblank event pulses and a completed-frame counter.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int H_FP      = H_FP_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BP      = H_BP_DEF,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int V_FP      = V_FP_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BP      = V_BP_DEF,
    parameter bit HS_POL    = SYNC_ACTIVE_LOW,
    parameter bit VS_POL    = SYNC_ACTIVE_LOW,
    parameter int CW        = CW_DEF,
    parameter int LOOKAHEAD = 2,
    parameter int FCW       = FCW_DEF
) (
    input logic              clk,
    input logic              reset,
    input logic              pix_en,
    vga_timing_gen_if.master vid
);
    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HS_LO   = H_ACTIVE + H_FP;
    localparam int HS_HI   = HS_LO + H_SYNC;
    localparam int VS_LO   = V_ACTIVE + V_FP;
    localparam int VS_HI   = VS_LO + V_SYNC;
    localparam bit FDE_RST = (LOOKAHEAD < H_ACTIVE);

    function automatic logic in_win(input int v, input int lo, input int hi);
        return (v >= lo) && (v < hi);
    endfunction

    logic [CW-1:0] x, y, fx, fy;
    logic [CW-1:0] x_n, y_n, fx_n, fy_n;
    logic          x_wrap, y_wrap, fx_wrap, fy_wrap;

    vga_axis_counter #(.TOTAL(H_TOTAL), .RESET_VAL(0), .CW(CW)) u_x (
        .clk(clk), .reset(reset), .en(pix_en), .count(x), .wrap(x_wrap));
    vga_axis_counter #(.TOTAL(V_TOTAL), .RESET_VAL(0), .CW(CW)) u_y (
        .clk(clk), .reset(reset), .en(x_wrap), .count(y), .wrap(y_wrap));
    vga_axis_counter #(.TOTAL(H_TOTAL), .RESET_VAL(LOOKAHEAD), .CW(CW)) u_fx (
        .clk(clk), .reset(reset), .en(pix_en), .count(fx), .wrap(fx_wrap));
    vga_axis_counter #(.TOTAL(V_TOTAL), .RESET_VAL(0), .CW(CW)) u_fy (
        .clk(clk), .reset(reset), .en(fx_wrap), .count(fy), .wrap(fy_wrap));

    // Mirror of the counters' next state so registered outputs line up with x,y (no skew).
    always_comb begin
        x_n  = x_wrap  ? '0 : (pix_en  ? x  + 1'b1 : x);
        y_n  = y_wrap  ? '0 : (x_wrap  ? y  + 1'b1 : y);
        fx_n = fx_wrap ? '0 : (pix_en  ? fx + 1'b1 : fx);
        fy_n = fy_wrap ? '0 : (fx_wrap ? fy + 1'b1 : fy);
    end

    logic           hsync_q, hsync_d, vsync_q, vsync_d, blank_q, blank_d, de_q, de_d;
    logic           fetch_de_q, fetch_de_d;
    logic           line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic           vblank_start_q, vblank_start_d;
    logic [FCW-1:0] frame_count_q, frame_count_d;

    always_comb begin
        hsync_d        = in_win(int'(x_n), HS_LO, HS_HI) ? HS_POL : ~HS_POL;
        vsync_d        = in_win(int'(y_n), VS_LO, VS_HI) ? VS_POL : ~VS_POL;
        blank_d        = (int'(x_n) >= H_ACTIVE) || (int'(y_n) >= V_ACTIVE);
        de_d           = ~blank_d;
        fetch_de_d     = (int'(fx_n) < H_ACTIVE) && (int'(fy_n) < V_ACTIVE);
        line_start_d   = x_wrap;
        frame_start_d  = x_wrap && y_wrap;
        vblank_start_d = x_wrap && (int'(y_n) == V_ACTIVE);
        frame_count_d  = frame_count_q;
        if (frame_start_d) frame_count_d = frame_count_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync_q        <= ~HS_POL;
            vsync_q        <= ~VS_POL;
            blank_q        <= 1'b0;
            de_q           <= 1'b1;
            fetch_de_q     <= FDE_RST;
            line_start_q   <= 1'b0;
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
            frame_count_q  <= '0;
        end else begin
            hsync_q        <= hsync_d;
            vsync_q        <= vsync_d;
            blank_q        <= blank_d;
            de_q           <= de_d;
            fetch_de_q     <= fetch_de_d;
            line_start_q   <= line_start_d;
            frame_start_q  <= frame_start_d;
            vblank_start_q <= vblank_start_d;
            frame_count_q  <= frame_count_d;
        end
    end

    assign vid.hsync        = hsync_q;
    assign vid.vsync        = vsync_q;
    assign vid.blank        = blank_q;
    assign vid.de           = de_q;
    assign vid.x            = x;
    assign vid.y            = y;
    assign vid.fetch_x      = fx;
    assign vid.fetch_y      = fy;
    assign vid.fetch_de     = fetch_de_q;
    assign vid.line_start   = line_start_q;
    assign vid.frame_start  = frame_start_q;
    assign vid.vblank_start = vblank_start_q;
    assign vid.frame_count  = frame_count_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 build for line-level timing, plus a tiny HS/VS active-high
// build (14x8 raster, 2-bit frame counter) for frame wrap, vsync, fetch wrap and mid-frame reset.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst0, rst1, en0, en1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.CW(10), .FCW(8)) v0 ();
    vga_timing_gen_if #(.CW(4),  .FCW(2)) v1 ();

    vga_timing_gen dut0 (.clk(clk), .reset(rst0), .pix_en(en0), .vid(v0));

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(4), .LOOKAHEAD(2), .FCW(2)
    ) dut1 (.clk(clk), .reset(rst1), .pix_en(en1), .vid(v1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int hs_low, n_ls, ls_at0, ls_at1, ex, ey, efx, efy, efc, n_fs, n_vb;
        bit exp_ls, exp_fs, exp_vb, reached;
        rst0 = 1'b1; rst1 = 1'b1; en0 = 1'b1; en1 = 1'b1;
        repeat (3) tick();

        // ---- default build: reset state, then one full line
        rst0 = 1'b0;
        check("rst_x", v0.x, 0);
        check("rst_y", v0.y, 0);
        check("rst_hsync", v0.hsync, 1);
        check("rst_vsync", v0.vsync, 1);
        check("rst_blank", v0.blank, 0);
        check("rst_de", v0.de, 1);
        check("rst_fetch_x", v0.fetch_x, 2);
        check("rst_fetch_y", v0.fetch_y, 0);
        check("rst_fetch_de", v0.fetch_de, 1);
        check("rst_pulses", {v0.line_start, v0.frame_start, v0.vblank_start}, 0);
        check("rst_fcount", v0.frame_count, 0);

        hs_low = 0;
        for (int k = 1; k < 800; k++) begin
            tick();
            check("l0_x", v0.x, k);
            check("l0_y", v0.y, 0);
            check("l0_hsync", v0.hsync, !(k >= 656 && k < 752));
            check("l0_vsync", v0.vsync, 1);
            check("l0_blank", v0.blank, k >= 640);
            check("l0_de", v0.de, k < 640);
            check("l0_fetch_x", v0.fetch_x, (k + 2) % 800);
            check("l0_fetch_y", v0.fetch_y, (k + 2) >= 800);
            check("l0_fetch_de", v0.fetch_de, ((k + 2) % 800) < 640);
            check("l0_ls", v0.line_start, 0);
            if (!v0.hsync) hs_low++;
        end
        check("hsync_width", hs_low, 96);
        check("fde_638", v0.fetch_de, 1);  // at x=799 fetch is (1,1): active again
        tick();
        check("wrap_x", v0.x, 0);
        check("wrap_y", v0.y, 1);
        check("wrap_ls", v0.line_start, 1);
        check("wrap_fs", v0.frame_start, 0);
        check("wrap_fetch_x", v0.fetch_x, 2);
        check("wrap_fetch_y", v0.fetch_y, 1);
        check("wrap_hsync", v0.hsync, 1);
        tick();
        check("ls_one_clk", v0.line_start, 0);
        check("x_after_wrap", v0.x, 1);

        // ---- pixel enable 1 clk in 4: line period 3200 clks, state held between ticks
        ex = 1; ey = 1; n_ls = 0; ls_at0 = 0; ls_at1 = 0;
        for (int c = 0; c < 6600; c++) begin
            en0 = (c % 4 == 0);
            tick();
            exp_ls = 1'b0;
            if (en0) begin
                if (ex == 799) begin ex = 0; ey = ey + 1; exp_ls = 1'b1; end
                else ex = ex + 1;
            end
            check("pe_x", v0.x, ex);
            check("pe_y", v0.y, ey);
            check("pe_ls", v0.line_start, exp_ls);
            check("pe_hsync", v0.hsync, !(ex >= 656 && ex < 752));
            check("pe_blank", v0.blank, ex >= 640);
            if (v0.line_start) begin
                if (n_ls == 0) ls_at0 = c;
                else if (n_ls == 1) ls_at1 = c;
                n_ls++;
            end
        end
        en0 = 1'b1;
        check("pe_ls_count", n_ls, 2);
        check("pe_line_period", ls_at1 - ls_at0, 3200);

        // async reset mid-line on the default build
        #3 rst0 = 1'b1;
        #1;
        check("mrst0_x", v0.x, 0);
        check("mrst0_y", v0.y, 0);
        check("mrst0_hsync", v0.hsync, 1);
        check("mrst0_fetch_x", v0.fetch_x, 2);
        check("mrst0_de", v0.de, 1);

        // ---- small build: reset values with active-high syncs
        check("s_rst_x", v1.x, 0);
        check("s_rst_hsync", v1.hsync, 0);
        check("s_rst_vsync", v1.vsync, 0);
        check("s_rst_blank", v1.blank, 0);
        check("s_rst_fetch_x", v1.fetch_x, 2);
        check("s_rst_fetch_de", v1.fetch_de, 1);
        check("s_rst_fcount", v1.frame_count, 0);
        tick();
        rst1 = 1'b0;

        // five frames plus a few ticks against a step model
        ex = 0; ey = 0; efx = 2; efy = 0; efc = 0; n_fs = 0; n_vb = 0;
        for (int c = 0; c < 5 * 112 + 3; c++) begin
            tick();
            if (ex == 13) begin ex = 0; ey = (ey == 7) ? 0 : ey + 1; end else ex = ex + 1;
            if (efx == 13) begin efx = 0; efy = (efy == 7) ? 0 : efy + 1; end else efx = efx + 1;
            exp_fs = (ex == 0 && ey == 0);
            exp_vb = (ex == 0 && ey == 4);
            if (exp_fs) efc = (efc + 1) % 4;
            check("s_x", v1.x, ex);
            check("s_y", v1.y, ey);
            check("s_fetch_x", v1.fetch_x, efx);
            check("s_fetch_y", v1.fetch_y, efy);
            check("s_hsync", v1.hsync, ex >= 10 && ex < 13);
            check("s_vsync", v1.vsync, ey >= 5 && ey < 7);
            check("s_blank", v1.blank, ex >= 8 || ey >= 4);
            check("s_de", v1.de, ex < 8 && ey < 4);
            check("s_fetch_de", v1.fetch_de, efx < 8 && efy < 4);
            check("s_ls", v1.line_start, ex == 0);
            check("s_fs", v1.frame_start, exp_fs);
            check("s_vb", v1.vblank_start, exp_vb);
            check("s_fcount", v1.frame_count, efc);
            if (ex == 13 && ey == 7) begin
                check("s_fetch_wrap_x", v1.fetch_x, 1);
                check("s_fetch_wrap_y", v1.fetch_y, 0);
            end
            if (ex == 6) check("s_fde_at_6", v1.fetch_de, 0);
            if (v1.frame_start) n_fs++;
            if (v1.vblank_start) n_vb++;
        end
        check("s_fs_count", n_fs, 5);
        check("s_vb_count", n_vb, 5);
        check("s_fcount_wrapped", v1.frame_count, 1);

        // walk to (5,3), then reset asynchronously mid-frame
        reached = 1'b0;
        for (int c = 0; c < 200 && !reached; c++) begin
            tick();
            reached = (v1.x == 4'd5 && v1.y == 4'd3);
        end
        check("s_reach_5_3", reached, 1);
        #3 rst1 = 1'b1;
        #1;
        check("mrst_x", v1.x, 0);
        check("mrst_y", v1.y, 0);
        check("mrst_fetch_x", v1.fetch_x, 2);
        check("mrst_fetch_y", v1.fetch_y, 0);
        check("mrst_hsync", v1.hsync, 0);
        check("mrst_vsync", v1.vsync, 0);
        check("mrst_blank", v1.blank, 0);
        check("mrst_pulses", {v1.line_start, v1.frame_start, v1.vblank_start}, 0);
        check("mrst_fcount", v1.frame_count, 0);

        // first frame_start comes at the first frame wrap, not at release
        rst1 = 1'b0;
        n_fs = 0;
        for (int c = 0; c < 111; c++) begin
            tick();
            if (v1.frame_start) n_fs++;
        end
        check("s_no_fs_at_release", n_fs, 0);
        tick();
        check("s_first_fs", v1.frame_start, 1);
        check("s_first_fs_ls", v1.line_start, 1);
        check("s_first_fs_x", v1.x, 0);
        check("s_first_fs_y", v1.y, 0);
        check("s_first_fcount", v1.frame_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
